// File: rtl/pkg_voice.sv
// Shared types and constants for the time-shared sine voice scheduler.
// Holds the scheduler FSM state enum, the default voice count and the
// per-voice cycle cost (SETUP, SAMPLE, ACCUM).
package pkg_voice;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SAMPLE,
    ST_ACCUM,
    ST_DONE
  } state_t;

  localparam int DEF_NUM_VOICES = 4;
  localparam int CYC_PER_VOICE  = 3;

  // Peak sine magnitude; the phase is a 15-bit angle spanning one full turn.
  localparam int SINE_AMP   = 262144;
  localparam int PHASE_BITS = 15;

endpackage

// File: rtl/mod_sinesource.sv
// Sine generator: sine(2*pi*step/period), peak SINE_AMP, quarter-wave table.
// Ports: clk, rst_n (sync, active-low), load latches step/period, capture
// registers the computed sample into sine. One load-to-capture cycle.
module mod_sinesource
  import pkg_voice::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               capture,
  input  logic signed [31:0] step,
  input  logic signed [31:0] period,
  output logic signed [31:0] sine
);

  logic signed [31:0] step_q;
  logic signed [31:0] period_q;
  logic [47:0]        num;
  logic [47:0]        den;
  logic [5:0]         coarse;
  logic [4:0]         k;
  logic [31:0]        mag;
  logic signed [31:0] sine_c;

  // round(SINE_AMP * sin(i * pi/32)), i = 0..16
  function automatic logic [31:0] qsin(input logic [4:0] i);
    case (i)
      5'd0:    qsin = 32'd0;
      5'd1:    qsin = 32'd25695;
      5'd2:    qsin = 32'd51142;
      5'd3:    qsin = 32'd76096;
      5'd4:    qsin = 32'd100318;
      5'd5:    qsin = 32'd123574;
      5'd6:    qsin = 32'd145639;
      5'd7:    qsin = 32'd166302;
      5'd8:    qsin = 32'd185364;
      5'd9:    qsin = 32'd202640;
      5'd10:   qsin = 32'd217965;
      5'd11:   qsin = 32'd231190;
      5'd12:   qsin = 32'd242189;
      5'd13:   qsin = 32'd250856;
      5'd14:   qsin = 32'd257107;
      5'd15:   qsin = 32'd260882;
      5'd16:   qsin = 32'd262144;
      default: qsin = 32'd0;
    endcase
  endfunction

  always_comb begin
    num = {1'b0, step_q, 15'd0};
    // A non-positive period never reaches the divider; phase is forced to 0.
    den = (period_q > 0) ? {16'd0, period_q} : 48'd1;
    // coarse = angle[14:9]: half-turn sign, quadrant mirror, 16 steps/quadrant
    coarse = (period_q > 0 && step_q >= 0) ? 6'((num / den) >> 9) : 6'd0;
    k      = coarse[4] ? (5'd16 - {1'b0, coarse[3:0]}) : {1'b0, coarse[3:0]};
    mag    = qsin(k);
    sine_c = coarse[5] ? -$signed(mag) : $signed(mag);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_q   <= '0;
      period_q <= '0;
      sine     <= '0;
    end else begin
      if (load) begin
        step_q   <= step;
        period_q <= period;
      end
      if (capture) begin
        sine <= sine_c;
      end
    end
  end

endmodule

// File: rtl/mod_voice_scheduler.sv
// Time-shares one mod_sinesource across NUM_VOICES voices; each strobe runs
// a pass (3 cycles/voice) summing enabled voice sines into o_mix.
// Ports: sample strobe, per-voice config write, o_mix/o_mix_valid, o_busy, sticky o_overrun.
module mod_voice_scheduler
  import pkg_voice::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_sample_strobe,
  input  logic                          i_cfg_we,
  input  logic [$clog2(NUM_VOICES)-1:0] i_cfg_voice,
  input  logic signed [31:0]            i_cfg_period,
  input  logic                          i_cfg_enable,
  output logic signed [31:0]            o_mix,
  output logic                          o_mix_valid,
  output logic                          o_busy,
  output logic                          o_overrun
);

  localparam int VW = $clog2(NUM_VOICES);
  localparam logic [VW-1:0] LAST_VOICE = VW'(NUM_VOICES - 1);

  state_t             state;
  logic [VW-1:0]      vidx;
  logic signed [31:0] acc;
  logic signed [31:0] acc_next;
  logic               act_q;
  logic signed [31:0] sine_q;
  logic               cur_act;
  logic signed [31:0] tm_inc;

  logic signed [31:0] period_r [NUM_VOICES];
  logic               en_r     [NUM_VOICES];
  logic signed [31:0] tm_r     [NUM_VOICES];

  mod_sinesource u_sine (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .load    (state == ST_SETUP),
    .capture (state == ST_SAMPLE),
    .step    (tm_r[vidx]),
    .period  (period_r[vidx]),
    .sine    (sine_q)
  );

  // act_q is latched with the sine inputs so a mid-pass config change cannot
  // add or drop this pass's contribution.
  assign acc_next = acc + (act_q ? sine_q : 32'sd0);
  assign cur_act  = en_r[vidx] && (period_r[vidx] > 0);
  assign tm_inc   = tm_r[vidx] + 32'sd1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      vidx        <= '0;
      acc         <= '0;
      act_q       <= 1'b0;
      o_mix       <= '0;
      o_mix_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_overrun   <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        period_r[v] <= '0;
        en_r[v]     <= 1'b0;
        tm_r[v]     <= '0;
      end
    end else begin
      o_mix_valid <= 1'b0;
      if (i_sample_strobe && o_busy) begin
        o_overrun <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (i_sample_strobe) begin
            state  <= ST_SETUP;
            vidx   <= '0;
            acc    <= '0;
            o_busy <= 1'b1;
          end
        end
        ST_SETUP: begin
          act_q <= cur_act;
          state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          state <= ST_ACCUM;
        end
        ST_ACCUM: begin
          acc <= acc_next;
          if (cur_act) begin
            tm_r[vidx] <= (tm_inc >= period_r[vidx]) ? 32'sd0 : tm_inc;
          end else begin
            tm_r[vidx] <= '0;
          end
          if (vidx == LAST_VOICE) begin
            // o_mix is loaded here so it is stable during the valid cycle.
            o_mix       <= acc_next;
            o_mix_valid <= 1'b1;
            state       <= ST_DONE;
          end else begin
            vidx  <= vidx + 1'b1;
            state <= ST_SETUP;
          end
        end
        ST_DONE: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      // Placed after the ACCUM update so a same-cycle write wins.
      if (i_cfg_we) begin
        period_r[i_cfg_voice] <= i_cfg_period;
        en_r[i_cfg_voice]     <= i_cfg_enable;
        tm_r[i_cfg_voice]     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mod_voice_scheduler.sv
// Bench for mod_voice_scheduler: scoreboard of expected mixes from a real-valued
// sine model, pass timing, overrun, config races and mid-pass reset.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_mod_voice_scheduler;

  localparam int N   = 4;
  localparam int LAT = 3 * N + 1;

  logic               clk;
  logic               rst_n;
  logic               strobe;
  logic               cfg_we;
  logic [1:0]         cfg_voice;
  logic signed [31:0] cfg_period;
  logic               cfg_enable;
  logic signed [31:0] mix;
  logic               mix_valid;
  logic               busy;
  logic               overrun;

  int total = 0;
  int bad   = 0;
  int pulse_cnt = 0;
  int mon_exp;
  int exp_q[$];

  int m_per [N];
  int m_tm  [N];
  bit m_en  [N];

  mod_voice_scheduler #(.NUM_VOICES(N)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_sample_strobe (strobe),
    .i_cfg_we        (cfg_we),
    .i_cfg_voice     (cfg_voice),
    .i_cfg_period    (cfg_period),
    .i_cfg_enable    (cfg_enable),
    .o_mix           (mix),
    .o_mix_valid     (mix_valid),
    .o_busy          (busy),
    .o_overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%h) want %0d (0x%h) at %0t",
               tag, $signed(obs), obs, $signed(exp), exp, $time);
    end
  endtask

  function automatic int gsine(input int tm, input int per);
    longint ang;
    real r;
    if (per <= 0) return 0;
    ang = (longint'(tm) * 32768) / per;
    r = 262144.0 * $sin(2.0 * 3.14159265358979 * real'(ang) / 32768.0);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  task automatic model_reset();
    for (int v = 0; v < N; v++) begin
      m_per[v] = 0;
      m_tm[v]  = 0;
      m_en[v]  = 1'b0;
    end
  endtask

  task automatic model_pass();
    int s;
    s = 0;
    for (int v = 0; v < N; v++) begin
      if (m_en[v] && m_per[v] > 0) begin
        s += gsine(m_tm[v], m_per[v]);
        m_tm[v] = (m_tm[v] + 1 >= m_per[v]) ? 0 : m_tm[v] + 1;
      end
    end
    exp_q.push_back(s);
  endtask

  task automatic set_voice(input int v, input int per, input bit en);
    cfg_we     = 1'b1;
    cfg_voice  = 2'(v);
    cfg_period = per;
    cfg_enable = en;
    @(negedge clk);
    cfg_we = 1'b0;
    m_per[v] = per;
    m_en[v]  = en;
    m_tm[v]  = 0;
  endtask

  // One pass from a strobe; optional extra strobe / config write at cycle k.
  task automatic do_pass(input int extra_at, input int cfg_at,
                         input int cv, input int cp, input bit ce);
    int p0;
    p0 = pulse_cnt;
    strobe = 1'b1;
    model_pass();
    @(negedge clk);
    for (int k = 1; k <= LAT; k++) begin
      strobe = 1'b0;
      cfg_we = 1'b0;
      check($sformatf("busy_c%0d", k), 32'(busy), 32'd1);
      check($sformatf("valid_c%0d", k), 32'(mix_valid), (k == LAT) ? 32'd1 : 32'd0);
      if (k == extra_at) strobe = 1'b1;
      if (k == cfg_at) begin
        cfg_we     = 1'b1;
        cfg_voice  = 2'(cv);
        cfg_period = cp;
        cfg_enable = ce;
        m_per[cv] = cp;
        m_en[cv]  = ce;
        m_tm[cv]  = 0;
      end
      @(negedge clk);
    end
    strobe = 1'b0;
    cfg_we = 1'b0;
    check("busy_after", 32'(busy), 32'd0);
    check("valid_after", 32'(mix_valid), 32'd0);
    check("pulses_per_pass", pulse_cnt - p0, 32'd1);
  endtask

  always @(negedge clk) begin
    if (mix_valid) begin
      pulse_cnt++;
      check("mix_known", 32'($isunknown(mix)), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("mix", mix, mon_exp);
      end
    end
  end

  initial begin
    int p0;
    rst_n = 1'b0; strobe = 1'b0; cfg_we = 1'b0;
    cfg_voice = '0; cfg_period = '0; cfg_enable = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_mix", mix, 32'd0);
    check("rst_valid", 32'(mix_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // all voices disabled
    do_pass(0, 0, 0, 0, 0);

    // voice0 period 4: 0, +A, 0, -A, then wrap to 0
    set_voice(0, 4, 1'b1);
    repeat (5) do_pass(0, 0, 0, 0, 0);

    // voice1 zero period, enabled: contributes nothing, time stays 0
    set_voice(1, 0, 1'b1);
    repeat (2) do_pass(0, 0, 0, 0, 0);
    check("t1_held", dut.tm_r[1], 32'd0);

    // several voices mixed, including negative sums
    set_voice(2, 8, 1'b1);
    set_voice(3, 2, 1'b1);
    repeat (8) do_pass(0, 0, 0, 0, 0);

    // config write to voice0 during its ACCUM cycle wins
    do_pass(0, 3, 0, 8, 1'b1);
    repeat (3) do_pass(0, 0, 0, 0, 0);

    // overrun: strobe mid-pass and in DONE
    check("overrun_clear", 32'(overrun), 32'd0);
    do_pass(5, 0, 0, 0, 0);
    check("overrun_set", 32'(overrun), 32'd1);
    do_pass(LAT, 0, 0, 0, 0);
    do_pass(0, 0, 0, 0, 0);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // reset at cycle 7 of a pass
    p0 = pulse_cnt;
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("abort_mix", mix, 32'd0);
    check("abort_valid", 32'(mix_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    check("abort_no_pulse", pulse_cnt - p0, 32'd0);
    do_pass(0, 0, 0, 0, 0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_voice_scheduler.md
MOD_VOICE_SCHEDULER -- requirements
Module: mod_voice_scheduler

Interface
REQ-001 Parameter NUM_VOICES, default 4: number of sine voices time-sharing one mod_sinesource; power of two, 2..16.
REQ-002 i_clk  input  1  single clock; all logic on the rising edge.
REQ-003 i_rst_n  input  1  reset, synchronous, active-low.
REQ-004 i_sample_strobe  input  1  one-cycle pulse per audio sample; starts one mix pass.
REQ-005 i_cfg_we  input  1  configuration write enable.
REQ-006 i_cfg_voice  input  $clog2(NUM_VOICES)  voice index for the write.
REQ-007 i_cfg_period  input  32 signed  period in samples for the written voice.
REQ-008 i_cfg_enable  input  1  enable bit for the written voice.
REQ-009 o_mix  output  32 signed  sum of enabled voice sines for the last pass.
REQ-010 o_mix_valid  output  1  one-cycle pulse when o_mix updates.
REQ-011 o_busy  output  1  high while a pass is in progress.
REQ-012 o_overrun  output  1  sticky; set when a strobe arrives while busy.

Function
REQ-013 Per-voice state SHALL be period[v] (32b), enable[v] (1b) and time[v] (32b signed).
REQ-014 FSM states SHALL be IDLE, SETUP, SAMPLE, ACCUM and DONE, with voice counter vidx.
REQ-015 IDLE + i_sample_strobe -> SETUP, vidx=0, accumulator=0; otherwise stay in IDLE.
REQ-016 SETUP: register time[vidx] and period[vidx] into the sinesource input registers -> SAMPLE.
REQ-017 SAMPLE: register the sinesource o_sine into sine_q -> ACCUM.
REQ-018 ACCUM: if the voice is active, add sine_q to the 32b accumulator and advance time[vidx]; if vidx is the last voice -> DONE, else vidx+1 -> SETUP.
REQ-019 DONE: o_mix<=accumulator, o_mix_valid=1 for exactly this cycle -> IDLE.
REQ-020 Latency: strobe sampled at edge E0 -> o_mix_valid high in cycle 3*NUM_VOICES+1 after E0 (13 for NUM_VOICES=4); o_busy high in cycles 1..3*NUM_VOICES+1.
REQ-021 Voice active = enable[v] and period[v]>0; an inactive voice contributes 0 and its time[v] is held at 0, so the divider never sees a zero period.
REQ-022 Time advance: time[v] <= (time[v]+1 >= period[v]) ? 0 : time[v]+1; time stays in 0..period-1.
REQ-023 Width: each sine is within +/-2^18; NUM_VOICES<=16 keeps the sum under 2^23, so the 32b sum SHALL be plain wrapping addition without saturation.
REQ-024 Config write: period[i_cfg_voice]<=i_cfg_period, enable<=i_cfg_enable, time<=0, accepted in any state.
REQ-025 A config write on the same cycle as that voice's ACCUM wins; time becomes 0 and no increment occurs.
REQ-026 A config write to a voice already latched in SETUP does not alter the current pass's sine; it takes effect from the next pass.
REQ-027 Strobe while o_busy=1 SHALL be ignored and set o_overrun; only reset clears o_overrun.
REQ-028 A strobe in the DONE cycle counts as overrun; a strobe in IDLE on the cycle after DONE starts a new pass.

Reset
REQ-029 While i_rst_n=0 at an edge: FSM=IDLE, vidx=0, accumulator=0, o_mix=0, o_mix_valid=0, o_busy=0, o_overrun=0.
REQ-030 Reset also clears all period[], enable[] and time[] to 0, and clears the sinesource input registers and sine_q.
REQ-031 Reset mid-pass aborts the pass with no o_mix_valid pulse; the first strobe after release starts a fresh pass.

Structure
REQ-032 Package pkg_voice SHALL hold the state enum typedef, default NUM_VOICES and the 3-cycles-per-voice constant.
REQ-033 One mod_sinesource instance SHALL be the sole sine datapath, with registered inputs and output.
REQ-034 No further sub-module; the config register file stays inline.

Verification
REQ-035 Reset then strobe with all voices disabled -> o_mix_valid at cycle 13, o_mix=0, o_busy high for cycles 1..13.
REQ-036 Voice0 period=4 enabled, four strobes -> o_mix matches the golden mod_sinesource model at time 0,1,2,3 (angles 0, 8192, 16384, 24576); the first pass gives 0.
REQ-037 Fifth strobe after REQ-036 -> time wrapped, o_mix equals the pass-1 value (0).
REQ-038 Strobe again at cycle 5 of a pass -> o_overrun=1, exactly one valid pulse, o_overrun stays set until reset.
REQ-039 Voice1 period=0 with enable=1 -> contributes 0, time[1] stays 0, no X or divide error.
REQ-040 Assert i_rst_n=0 at cycle 7 of a pass -> no valid pulse, all outputs 0; a strobe after release gives valid 13 cycles later.
